// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: word/block widths, key-schedule FSM encoding, Rcon and RotWord helpers.
package aes_pkg;

   localparam int WORD_W     = 32;
   localparam int BLOCK_W    = 128;
   localparam int NUM_ROUNDS = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_OUTPUT = 2'd2
   } state_t;

   // Round constant for round index 1..10, in the top byte of the word.
   function automatic logic [WORD_W-1:0] rcon(input logic [3:0] rnd);
      logic [7:0] b;
      case (rnd)
         4'd1:    b = 8'h01;
         4'd2:    b = 8'h02;
         4'd3:    b = 8'h04;
         4'd4:    b = 8'h08;
         4'd5:    b = 8'h10;
         4'd6:    b = 8'h20;
         4'd7:    b = 8'h40;
         4'd8:    b = 8'h80;
         4'd9:    b = 8'h1b;
         4'd10:   b = 8'h36;
         default: b = 8'h00;
      endcase
      return {b, 24'h000000};
   endfunction

   function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, zero latency, no flow control.
// Table is row-major from byte 0x00 at the MSB end, so entry v sits at bit offset 8*(255-v).
module aes_sbox (
   input  logic [7:0] val,
   output logic [7:0] sub
);

   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign sub = SBOX_TABLE[{~val, 3'b000} +: 8];

endmodule

// File: rtl/inv_key_schedule.sv
// AES-128 reverse-order round-key generator: 10-cycle forward expansion, then keys 10..0, one per next.
// Each key is held until next; at most one key per cycle, and the key after round 0 is never stored.
module inv_key_schedule
   import aes_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [BLOCK_W-1:0] key_in,
   output logic               ready,
   output logic               key_valid,
   output logic [BLOCK_W-1:0] round_key,
   output logic [3:0]         round_num,
   input  logic               next,
   output logic               done
);

   state_t             state, state_nxt;
   logic [BLOCK_W-1:0] rk, rk_nxt;
   logic [3:0]         rnd, rnd_nxt;
   logic               done_nxt;

   logic [WORD_W-1:0] w0, w1, w2, w3;
   logic [WORD_W-1:0] sub_in, sub_out, t;
   logic [WORD_W-1:0] f0, f1, f2, f3;
   logic [BLOCK_W-1:0] fwd_rk, inv_rk;

   assign {w0, w1, w2, w3} = rk;

   // One shared SubWord: the inverse step needs the recovered w3, which is w3^w2.
   assign sub_in = rot_word((state == ST_OUTPUT) ? (w3 ^ w2) : w3);

   for (genvar i = 0; i < 4; i++) begin : g_subword
      aes_sbox u_sbox (
         .val (sub_in[8*i +: 8]),
         .sub (sub_out[8*i +: 8])
      );
   end

   assign t      = sub_out ^ rcon(rnd + 4'd1);
   assign f0     = w0 ^ t;
   assign f1     = w1 ^ f0;
   assign f2     = w2 ^ f1;
   assign f3     = w3 ^ f2;
   assign fwd_rk = {f0, f1, f2, f3};
   assign inv_rk = {w0 ^ sub_out ^ rcon(rnd), w1 ^ w0, w2 ^ w1, w3 ^ w2};

   always_comb begin
      state_nxt = state;
      rk_nxt    = rk;
      rnd_nxt   = rnd;
      done_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               rk_nxt    = key_in;
               rnd_nxt   = 4'd0;
               state_nxt = ST_EXPAND;
            end
         end
         ST_EXPAND: begin
            rk_nxt  = fwd_rk;
            rnd_nxt = rnd + 4'd1;
            if (rnd == 4'(NUM_ROUNDS - 1)) begin
               state_nxt = ST_OUTPUT;
            end
         end
         ST_OUTPUT: begin
            if (next) begin
               if (rnd != 4'd0) begin
                  rk_nxt  = inv_rk;
                  rnd_nxt = rnd - 4'd1;
               end else begin
                  rk_nxt    = '0;
                  done_nxt  = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            rk_nxt    = '0;
            rnd_nxt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         rk    <= '0;
         rnd   <= 4'd0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         rk    <= rk_nxt;
         rnd   <= rnd_nxt;
         done  <= done_nxt;
      end
   end

   assign ready     = (state == ST_IDLE);
   assign key_valid = (state == ST_OUTPUT);
   assign round_key = key_valid ? rk : '0;
   assign round_num = key_valid ? rnd : 4'd0;

endmodule
